multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Control unit for the multicycle RV32I datapath. It decodes the latched instruction's opcode and function fields and sequences the datapath through Fetch/Decode/Execute/Memory/Writeback. It drives every datapath mux select and write strobe, and it produces the 3-bit `ALUControl` code consumed directly by the ALU. It supports the subset lw, sw, R-type (add/sub/and/or/slt), I-type ALU (addi/andi/ori/slti), beq and jal.

## Interface
Parameters: none.
- `clk`  in  1  system clock; all state changes on the rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `op`  in  7  instruction bits [6:0], from the instruction register
- `funct3`  in  3  instruction bits [14:12]
- `funct7b5`  in  1  instruction bit 30
- `Zero`  in  1  ALU zero flag, combinational from the current ALU result
- `PCWrite`  out  1  PC register enable
- `AdrSrc`  out  1  memory address select: 0 = PC, 1 = Result
- `MemWrite`  out  1  data memory write strobe
- `IRWrite`  out  1  instruction register / OldPC enable
- `RegWrite`  out  1  register file write strobe
- `ResultSrc`  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult
- `ALUSrcA`  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = register A
- `ALUSrcB`  out  2  ALU B select: 00 = register WriteData, 01 = ImmExt, 10 = constant 4
- `ImmSrc`  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J
- `ALUControl`  out  3  ALU operation: 000 = add, 001 = sub, 010 = and, 011 = or, 101 = slt

## Operation
- **FSM type.** Moore FSM with 11 states in a 4-bit register. Internally it also produces `ALUOp` (2 bits), `Branch` and `PCUpdate`.
- **Common rule.** `PCWrite = PCUpdate | (Branch & Zero)`. All strobes and selects not listed for a state are 0.
- **State outputs and transitions:**
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1. Next: DECODE.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00. Next by `op`:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXECR
    - 0010011 → EXECI
    - 1101111 → JAL
    - 1100011 → BEQ
    - any other opcode → FETCH, with no strobe asserted
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next: MEMREAD if op=0000011, else MEMWRITE.
  - MEMREAD: ResultSrc=00, AdrSrc=1. Next: MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1. Next: FETCH.
  - MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1. Next: FETCH.
  - EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next: ALUWB.
  - EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next: ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1. Next: FETCH.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1. Next: ALUWB.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1. Next: FETCH.
- **ALU decode:**
  - ALUOp 00 → 000 (add).
  - ALUOp 01 → 001 (sub).
  - ALUOp 10 → decoded from funct3:
    - 000 → 001 if (op[5] & funct7b5), else 000
    - 010 → 101
    - 110 → 011
    - 111 → 010
    - any other funct3 → 000
  - ALUOp 11 → 000.
- **Immediate decode.** `ImmSrc` is combinational from `op`:
  - 0000011 or 0010011 → 00
  - 0100011 → 01
  - 1100011 → 10
  - 1101111 → 11
  - any other opcode → 00

## Timing
- **Reset.** While `rst_n`=0, PCWrite, IRWrite, RegWrite and MemWrite are forced to 0 combinationally. At a rising edge with `rst_n`=0, the state register loads FETCH. The first FETCH cycle is the first cycle with `rst_n`=1.
- **Reset values of outputs.** During reset, the non-strobe outputs show the FETCH values: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ResultSrc=10, ALUControl=000. ImmSrc follows `op`.
- **Reset mid-instruction.** Reset at any state aborts the instruction. No strobe from the aborted state may be asserted in the reset cycle.
- **Instruction latency** (cycles, FETCH through the last state): lw 5, sw 4, R-type 4, I-type 4, jal 4, beq 3, illegal 2.
- **Combinational paths.** `PCWrite` in BEQ depends combinationally on `Zero` in that same cycle. `ALUControl` and `ImmSrc` follow `op`, `funct3` and `funct7b5` combinationally. These inputs are stable from the cycle after FETCH onward.
- **No stalls.** Every state lasts exactly one cycle; the controller has no handshake.

## Structure
- **Shared include** `rv32i_defs.vh`, holding:
  - opcode constants (OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ)
  - ALUControl codes (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT)
  - the ResultSrc, ALUSrcA and ALUSrcB encodings
  
  State encodings stay local to the controller.
- **Sub-module** `alu_decoder`: purely combinational. Inputs: ALUOp, funct3, funct7b5, op5. Output: ALUControl. It is instantiated once and verified separately.

## Test plan
- **Reset.** Hold `rst_n`=0 for 3 cycles while op=0110011 → all strobes 0. After release, FETCH outputs: IRWrite=1, PCWrite=1, ALUSrcB=10.
- **R-type add vs sub.** op=0110011, funct3=000, funct7b5=0 → ALUControl=000 in EXECR; RegWrite=1 only in cycle 4; then FETCH. Repeat with funct7b5=1 → ALUControl=001.
- **addi vs R-type sub.** op=0010011, funct3=000, funct7b5=1 → ALUControl=000 (addi, not sub). ImmSrc=00, ALUSrcB=01 in EXECI.
- **beq.** op=1100011 with Zero=1 in cycle 3 → PCWrite=1, ALUControl=001. Repeat with Zero=0 → PCWrite=0. Return to FETCH in cycle 4.
- **lw and sw.** lw → 5-cycle sequence; AdrSrc=1 in cycle 4; RegWrite with ResultSrc=01 in cycle 5. sw (op=0100011) → MemWrite=1 only in cycle 4; ImmSrc=01.
- **Illegal opcode and mid-instruction reset.** op=0000000 → DECODE then FETCH, no RegWrite/MemWrite. Separately, assert `rst_n`=0 during MEMREAD of a lw → no RegWrite ever occurs; FETCH follows release.

Source files
------------

// File: rtl/multicycle_controller_pkg.sv
// Shared RV32I decode constants for the multicycle controller and its ALU decoder.
// Holds the opcodes, ALU operation codes and datapath mux encodings.
package multicycle_controller_pkg;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REG   = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// Combinational ALU decoder: maps ALUOp plus the instruction function fields
// onto the 3-bit operation code consumed by the ALU.
module alu_decoder
  import multicycle_controller_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        // funct7b5 only selects sub for register-register ops; addi's bit 30 is immediate data
        case (funct3)
          3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle RV32I datapath (lw, sw, R/I ALU, beq, jal).
// Sequences Fetch/Decode/Execute/Memory/Writeback and drives all selects and strobes.
module multicycle_controller
  import multicycle_controller_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_JAL, S_BEQ
  } state_t;

  state_t     state, next_state, cur_state;
  logic [1:0] alu_op;
  logic       branch, pc_update, ir_write, reg_write, mem_write;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= next_state;
  end

  always_comb begin
    next_state = S_FETCH;
    alu_op     = ALUOP_ADD;
    branch     = 1'b0;
    pc_update  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = RES_ALUOUT;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_REG;
    // Reset shows FETCH selects while the strobes below are gated off
    cur_state  = rst_n ? state : S_FETCH;
    case (cur_state)
      S_FETCH: begin
        ir_write   = 1'b1;
        pc_update  = 1'b1;
        ALUSrcB    = SRCB_FOUR;
        ResultSrc  = RES_ALURESULT;
        next_state = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_R:         next_state = S_EXECR;
          OP_I:         next_state = S_EXECI;
          OP_JAL:       next_state = S_JAL;
          OP_BEQ:       next_state = S_BEQ;
          default:      next_state = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA    = SRCA_REG;
        ALUSrcB    = SRCB_IMM;
        next_state = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc     = 1'b1;
        next_state = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc  = RES_DATA;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc     = 1'b1;
        mem_write  = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA    = SRCA_REG;
        alu_op     = ALUOP_FUNCT;
        next_state = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA    = SRCA_REG;
        ALUSrcB    = SRCB_IMM;
        alu_op     = ALUOP_FUNCT;
        next_state = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
      end
      S_JAL: begin
        ALUSrcA    = SRCA_OLDPC;
        ALUSrcB    = SRCB_FOUR;
        pc_update  = 1'b1;
        next_state = S_ALUWB;
      end
      S_BEQ: begin
        ALUSrcA    = SRCA_REG;
        alu_op     = ALUOP_SUB;
        branch     = 1'b1;
      end
      default: next_state = S_FETCH;
    endcase
    PCWrite  = rst_n & (pc_update | (branch & Zero));
    IRWrite  = rst_n & ir_write;
    RegWrite = rst_n & reg_write;
    MemWrite = rst_n & mem_write;
  end

  always_comb begin
    case (op)
      OP_LW, OP_I: ImmSrc = IMM_I;
      OP_SW:       ImmSrc = IMM_S;
      OP_BEQ:      ImmSrc = IMM_B;
      OP_JAL:      ImmSrc = IMM_J;
      default:     ImmSrc = IMM_I;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .op5         (op[5]),
    .alu_control (ALUControl)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed instruction sequences followed by random
// instruction streams, each cycle compared against a per-instruction-cycle reference table.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;

  int errors = 0;
  int checks = 0;

  localparam int C_LW = 0, C_SW = 1, C_R = 2, C_I = 3, C_JAL = 4, C_BEQ = 5, C_ILL = 6;

  multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(Zero),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ImmSrc(ImmSrc), .ALUControl(ALUControl)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] opcode_of(input int cls);
    case (cls)
      C_LW:    return 7'b0000011;
      C_SW:    return 7'b0100011;
      C_R:     return 7'b0110011;
      C_I:     return 7'b0010011;
      C_JAL:   return 7'b1101111;
      C_BEQ:   return 7'b1100011;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic int latency_of(input int cls);
    case (cls)
      C_LW:    return 5;
      C_BEQ:   return 3;
      C_ILL:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit is_legal(input logic [6:0] o);
    return o == 7'b0000011 || o == 7'b0100011 || o == 7'b0110011 ||
           o == 7'b0010011 || o == 7'b1101111 || o == 7'b1100011;
  endfunction

  // Expected output word {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ImmSrc,ALUControl}
  function automatic logic [15:0] model(input int cls, input int k, input logic [6:0] o,
                                        input logic [2:0] f3, input logic f7, input logic z,
                                        input logic in_reset);
    logic pcw, adr, mw, irw, rw;
    logic [1:0] res, sa, sb, imm;
    logic [2:0] alu, fn;
    pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0;
    res = 2'b00; sa = 2'b00; sb = 2'b00; alu = 3'b000;
    if (o == 7'b0100011)      imm = 2'b01;
    else if (o == 7'b1100011) imm = 2'b10;
    else if (o == 7'b1101111) imm = 2'b11;
    else                      imm = 2'b00;
    if (f3 == 3'b000)      fn = (o[5] && f7) ? 3'b001 : 3'b000;
    else if (f3 == 3'b010) fn = 3'b101;
    else if (f3 == 3'b110) fn = 3'b011;
    else if (f3 == 3'b111) fn = 3'b010;
    else                   fn = 3'b000;
    if (in_reset) begin
      sb = 2'b10; res = 2'b10;
    end else if (k == 0) begin
      irw = 1; pcw = 1; sb = 2'b10; res = 2'b10;
    end else if (k == 1) begin
      sa = 2'b01; sb = 2'b01;
    end else begin
      case (cls)
        C_LW, C_SW: begin
          if (k == 2) begin sa = 2'b10; sb = 2'b01; end
          else if (k == 3) begin adr = 1; mw = (cls == C_SW); end
          else begin res = 2'b01; rw = 1; end
        end
        C_R, C_I: begin
          if (k == 2) begin sa = 2'b10; sb = (cls == C_I) ? 2'b01 : 2'b00; alu = fn; end
          else rw = 1;
        end
        C_JAL: begin
          if (k == 2) begin sa = 2'b01; sb = 2'b10; pcw = 1; end
          else rw = 1;
        end
        C_BEQ: begin
          sa = 2'b10; alu = 3'b001; pcw = z;
        end
        default: ;
      endcase
    end
    return {pcw, adr, mw, irw, rw, res, sa, sb, imm, alu};
  endfunction

  task automatic check_output(input string tag, input logic [15:0] expv);
    logic [15:0] obs;
    obs = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl};
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Runs one instruction from its FETCH cycle; entered and left at posedge+1.
  // zsel: 0/1 force Zero, 2 randomizes it every cycle.
  task automatic apply_stimulus(input int cls, input logic [6:0] o, input logic [2:0] f3,
                                input logic f7, input int zsel, input int upto);
    int n;
    op = o; funct3 = f3; funct7b5 = f7;
    n = (upto >= 0) ? upto : latency_of(cls);
    for (int k = 0; k < n; k++) begin
      Zero = (zsel == 2) ? 1'($urandom_range(0, 1)) : (zsel == 1);
      #2;
      check_output($sformatf("op%b_f3%b_f7%b_cyc%0d", o, f3, f7, k + 1),
                   model(cls, k, o, f3, f7, Zero, 1'b0));
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [6:0] rop;
    int         cls;
    rst_n = 1'b0; op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0; Zero = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      #2;
      check_output($sformatf("reset_cyc%0d", i), model(C_R, 0, op, funct3, funct7b5, Zero, 1'b1));
      @(posedge clk); #1;
    end
    rst_n = 1'b1;

    apply_stimulus(C_R,   7'b0110011, 3'b000, 1'b0, 2, -1);
    apply_stimulus(C_R,   7'b0110011, 3'b000, 1'b1, 2, -1);
    apply_stimulus(C_I,   7'b0010011, 3'b000, 1'b1, 2, -1);
    apply_stimulus(C_BEQ, 7'b1100011, 3'b000, 1'b0, 1, -1);
    apply_stimulus(C_BEQ, 7'b1100011, 3'b000, 1'b0, 0, -1);
    apply_stimulus(C_LW,  7'b0000011, 3'b010, 1'b0, 2, -1);
    apply_stimulus(C_SW,  7'b0100011, 3'b010, 1'b0, 2, -1);
    apply_stimulus(C_ILL, 7'b0000000, 3'b000, 1'b0, 2, -1);
    apply_stimulus(C_JAL, 7'b1101111, 3'b101, 1'b1, 2, -1);

    // Abort a lw during its MEMREAD cycle; writeback must never happen
    apply_stimulus(C_LW, 7'b0000011, 3'b010, 1'b0, 2, 3);
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #2;
      check_output($sformatf("midreset_cyc%0d", i), model(C_LW, 3, op, funct3, funct7b5, Zero, 1'b1));
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    apply_stimulus(C_R, 7'b0110011, 3'b111, 1'b0, 2, -1);

    for (int n = 0; n < 80; n++) begin
      cls = $urandom_range(0, 6);
      rop = opcode_of(cls);
      if (cls == C_ILL) begin
        do rop = 7'($urandom); while (is_legal(rop));
      end
      apply_stimulus(cls, rop, 3'($urandom), 1'($urandom), 2, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
